// File: rtl/tim_arbiter_pkg.sv
// Shared request/owner types for the two-port TIM front end.
// Holds the pending-slot payload layout and helpers that pack a port's fields into it.
package tim_arb_wires;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } tim_arb_req_type;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } tim_arb_owner_type;

  localparam tim_arb_req_type init_req = '0;

  // Fetches never write, so their store fields are pinned to zero.
  function automatic tim_arb_req_type fetch_req(input logic valid, input logic [31:0] addr);
    tim_arb_req_type r;
    r       = init_req;
    r.valid = valid;
    r.instr = 1'b1;
    r.addr  = addr;
    return r;
  endfunction

  function automatic tim_arb_req_type data_req(input logic valid, input logic [31:0] addr,
                                               input logic [31:0] wdata, input logic [3:0] wstrb);
    tim_arb_req_type r;
    r       = init_req;
    r.valid = valid;
    r.instr = 1'b0;
    r.addr  = addr;
    r.wdata = wdata;
    r.wstrb = wstrb;
    return r;
  endfunction

  function automatic tim_arb_owner_type owner_of(input tim_arb_req_type r);
    if (!r.valid) return OWN_NONE;
    return r.instr ? OWN_FETCH : OWN_DATA;
  endfunction

endpackage

// File: rtl/tim_arbiter_slot.sv
// One-deep pending buffer for a request that lost arbitration.
// A load in the same cycle as a clear keeps the new request.
module tim_arb_slot
  import tim_arb_wires::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  tim_arb_req_type d,
  output tim_arb_req_type q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= init_req;
    end else if (load) begin
      q <= d;
    end else if (clear) begin
      q <= init_req;
    end
  end

endmodule

// File: rtl/tim_arbiter.sv
// Merges the fetch and data ports onto the single-cycle TIM request port and
// steers each TIM response back to the port that issued the matching request.
module tim_arbiter
  import tim_arb_wires::*;
#(
  parameter logic fair = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        tim_valid,
  output logic        tim_instr,
  output logic [31:0] tim_addr,
  output logic [31:0] tim_wdata,
  output logic [3:0]  tim_wstrb,
  input  logic [31:0] tim_rdata,
  input  logic        tim_ready,
  output logic [1:0]  dbg_owner,
  output logic        dbg_orphan
);

  // Handshake: *_valid is a one-cycle request pulse with no backpressure; the
  // matching *_ready pulse arrives exactly one cycle after the request reaches
  // tim, and the port may fire its next request in that same ready cycle.

  tim_arb_req_type   fresh_f, fresh_d;
  tim_arb_req_type   slot_f_q, slot_d_q;
  tim_arb_req_type   issue_req;
  tim_arb_owner_type owner, owner_next;
  logic              owner_store, owner_store_next;
  logic              armed;
  logic              last_grant;
  logic              orphan;
  logic              load_f, load_d, clear_f, clear_d;
  logic              conflict, grant_data;

  // Requests are ignored until the first edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  assign fresh_f = fetch_req(imem_valid && armed, imem_addr);
  assign fresh_d = data_req(dmem_valid && armed, dmem_addr, dmem_wdata, dmem_wstrb);

  // last_grant: 0 = fetch won the previous conflict, 1 = data won it.
  assign grant_data = fair ? !last_grant : 1'b1;

  always_comb begin
    issue_req = init_req;
    load_f    = 1'b0;
    load_d    = 1'b0;
    clear_f   = 1'b0;
    clear_d   = 1'b0;
    conflict  = 1'b0;
    if (slot_f_q.valid) begin
      issue_req = slot_f_q;
      clear_f   = 1'b1;
      load_d    = fresh_d.valid;
    end else if (slot_d_q.valid) begin
      issue_req = slot_d_q;
      clear_d   = 1'b1;
      load_f    = fresh_f.valid;
    end else if (fresh_f.valid && fresh_d.valid) begin
      conflict  = 1'b1;
      issue_req = grant_data ? fresh_d : fresh_f;
      load_f    = grant_data;
      load_d    = !grant_data;
    end else if (fresh_f.valid) begin
      issue_req = fresh_f;
    end else if (fresh_d.valid) begin
      issue_req = fresh_d;
    end
  end

  tim_arb_slot u_slot_f (
    .clock (clock),
    .reset (reset),
    .load  (load_f),
    .clear (clear_f),
    .d     (fresh_f),
    .q     (slot_f_q)
  );

  tim_arb_slot u_slot_d (
    .clock (clock),
    .reset (reset),
    .load  (load_d),
    .clear (clear_d),
    .d     (fresh_d),
    .q     (slot_d_q)
  );

  assign tim_valid = issue_req.valid;
  assign tim_instr = issue_req.instr;
  assign tim_addr  = issue_req.addr;
  assign tim_wdata = issue_req.wdata;
  assign tim_wstrb = issue_req.wstrb;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b0;
      orphan     <= 1'b0;
    end else begin
      if (conflict) last_grant <= grant_data;
      if (tim_ready && (owner == OWN_NONE)) orphan <= 1'b1;
    end
  end

  // Owner tracking: register, next-state, and response routing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner       <= OWN_NONE;
      owner_store <= 1'b0;
    end else begin
      owner       <= owner_next;
      owner_store <= owner_store_next;
    end
  end

  always_comb begin
    owner_next       = owner_of(issue_req);
    owner_store_next = issue_req.valid && !issue_req.instr && (issue_req.wstrb != 4'd0);
  end

  always_comb begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    if (tim_ready) begin
      case (owner)
        OWN_FETCH: begin
          imem_ready = 1'b1;
          imem_rdata = tim_rdata;
        end
        OWN_DATA: begin
          dmem_ready = 1'b1;
          if (!owner_store) dmem_rdata = tim_rdata;
        end
        default: ;
      endcase
    end
  end

  assign dbg_owner  = owner;
  assign dbg_orphan = orphan;

endmodule

// File: doc/tim_arbiter.md
# tim_arbiter

Two-port front end for the tightly-integrated memory: merges the core's instruction-fetch port and data load/store port onto the single `tim` request port and routes each `tim` response back to the port that issued it. Sits directly upstream of `tim`, one per core. Issues at most one request per cycle, buffers the losing request of a simultaneous pair one-deep per port, and relies on the fixed one-cycle `tim` response: request in cycle t, `tim_ready` in t+1.

## Interface
- `fair`, default 1: 1 = round-robin on simultaneous fresh requests; 0 = data port always wins.
- `reset`  in  1  asynchronous, active-low
- `clock`  in  1  single clock; all state on rising edge
- `imem_valid`  in  1  fetch request pulse, one cycle per request
- `imem_addr`  in  32  fetch byte address
- `imem_rdata`  out  32  fetch data; valid only with `imem_ready`, else 0
- `imem_ready`  out  1  fetch completion pulse
- `dmem_valid`  in  1  data request pulse
- `dmem_addr`  in  32  data byte address
- `dmem_wdata`  in  32  store data
- `dmem_wstrb`  in  4  byte strobes; 0 = load
- `dmem_rdata`  out  32  load data; valid only with `dmem_ready`, else 0
- `dmem_ready`  out  1  data completion pulse
- `tim_valid`, `tim_instr`  out  1, 1  request to `tim`; `tim_instr`=1 for fetch
- `tim_addr`, `tim_wdata`, `tim_wstrb`  out  32, 32, 4  request fields
- `tim_rdata`, `tim_ready`  in  32, 1  response from `tim`

## Operation
- Requester rule: a port issues no new request until its ready for the previous one; a new request is allowed in the same cycle as that ready. At most one pending request per port.
- Pending slot per port: {valid, addr, wdata, wstrb}. Fetch slot stores wstrb=0, wdata=0.
- Issue selection each cycle, first match wins:
  1. a pending slot (at most one can be valid at a time, by construction);
  2. exactly one fresh request, issued directly;
  3. both fresh: `fair`=1 grants the port not granted last conflict (`last_grant` bit, reset = fetch, so data wins first); `fair`=0 grants data. Loser goes to its slot.
- A fresh request arriving while that port's own slot is being issued is illegal per requester rule; arbiter behaviour undefined, bench asserts it never occurs.
- A fresh request from port A while port B's slot issues: A is written into A's slot.
- Outputs during issue: `tim_valid`=1, `tim_instr`=1 for fetch/0 for data, remaining fields from winner; otherwise all `tim_*` outputs 0.
- Owner register: {none, fetch, data}, loaded with the winner on issue, none when nothing issues.
- Response routing: in the cycle after an issue, `tim_ready` and `tim_rdata` go to the owner's ready/rdata. `tim_ready` with owner=none is dropped and sets sticky debug flag `orphan` (internal).
- Stores complete on the data port with `dmem_rdata`=0.

## Timing
- Reset (asynchronous, `reset`=0): slots invalid, owner=none, `last_grant`=fetch, `orphan`=0. `tim_*` request outputs, `imem_ready`, `dmem_ready` and both rdata outputs are 0 while held and in the first cycle after release.
- Outputs to `tim` are combinational from fresh inputs and registered slots; ready/rdata outputs are combinational from `tim_ready`/`tim_rdata` and the owner.
- Latency: direct issue, valid in t and ready in t+1. Buffered loser, ready in t+2.
- Throughput: one request per cycle sustained; no bubbles while any request is available.
- Reset mid-transaction: the in-flight response is discarded because owner is cleared; pending requests are lost. Requesters restart after reset.

## Structure
- Package `tim_arb_wires`: `tim_arb_req_type` packed struct {valid, instr, addr, wdata, wstrb}; `tim_arb_owner_type` enum {OWN_NONE, OWN_FETCH, OWN_DATA}; `init_req` constant.
- Sub-module `tim_arb_slot`: one-deep pending buffer holding `tim_arb_req_type`, with load and clear inputs and asynchronous reset. Instantiated twice.
- Top level holds selection logic, owner, `last_grant`, `orphan`, and response routing; wrapping `tim` is outside this block.

## Test plan
- Lone fetch, `imem_addr`=0x40, memory word 0xDEADBEEF: cycle t `tim_valid`=1, `tim_instr`=1, `tim_addr`=0x40; t+1 `imem_ready`=1, `imem_rdata`=0xDEADBEEF; `dmem_ready`=0.
- Simultaneous fetch 0x0 and load 0x100, `fair`=1, from reset: data issues in t with fetch ready in t+2; repeat pair then fetch issues first. With `fair`=0, data is first both times.
- Store 0x11223344, wstrb=0xF, to 0x200, then load 0x200 next cycle: `dmem_ready` in t+1 with rdata 0, `dmem_rdata`=0x11223344 in t+2.
- Back-to-back fetches 0x0, 0x4, 0x8 each issued on the prior ready: `tim_valid` high three consecutive cycles; three consecutive `imem_ready` pulses with correct data.
- Pending fetch plus fresh load in the next cycle: fetch slot issues first, load is buffered and issues the following cycle; no request is lost or duplicated.
- Assert `reset`=0 mid-cycle with a buffered request: all outputs go to 0 immediately; after release, no ready pulse from the stale transaction.
